// File: rtl/oven_timer.sv
// -----------------------------------------------------------------------------
// oven_timer
//   Cook-time sequencer for the microwave oven controller. Holds the
//   user-programmed cook time, issues a one-cycle start pulse to move the oven
//   controller into cooking, counts the time down in seconds while the oven
//   controller reports heat, and issues a one-cycle finish pulse at zero.
//
// Parameters
//   TICK_DIV  clock cycles per one-second tick (>= 2)
//   TW        width of the seconds counter
//   STEP      seconds added per add press
//
// Ports
//   clk        in   clock, rising edge
//   nrst       in   asynchronous active-low reset
//   add        in   one-cycle pulse: add STEP seconds
//   clr        in   one-cycle pulse: clear or abort
//   go         in   one-cycle pulse: request cooking
//   door       in   1 = door open
//   heat       in   oven controller's heat output
//   start      out  one-cycle pulse to the oven controller (registered)
//   finish     out  one-cycle pulse to the oven controller (registered)
//   remaining  out  seconds left, for display
//   running    out  high while counting down (registered)
// -----------------------------------------------------------------------------
module oven_timer #(
    parameter int TICK_DIV = 1000,
    parameter int TW       = 8,
    parameter int STEP     = 10
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          add,
    input  logic          clr,
    input  logic          go,
    input  logic          door,
    input  logic          heat,
    output logic          start,
    output logic          finish,
    output logic [TW-1:0] remaining,
    output logic          running
);

    localparam int             PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SET,
        ARM,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  prescaler, pre_nx;
    logic [TW-1:0]  rem_nx;
    logic           start_nx, finish_nx, running_nx;

    // Add STEP seconds, clamping at the all-ones value instead of wrapping.
    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] v);
        logic [TW:0] sum;
        sum = {1'b0, v} + (TW+1)'(STEP);
        if (sum[TW]) return '1;
        return sum[TW-1:0];
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            remaining <= '0;
            prescaler <= '0;
            start     <= 1'b0;
            finish    <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            prescaler <= pre_nx;
            start     <= start_nx;
            finish    <= finish_nx;
            running   <= running_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rem_nx    = remaining;
        pre_nx    = prescaler;
        start_nx  = 1'b0;
        finish_nx = 1'b0;

        case (state)
            IDLE: begin
                if (add) begin
                    rem_nx   = sat_add('0);
                    state_nx = SET;
                end
            end

            SET: begin
                // clr beats add beats go; a go coinciding with add is dropped.
                if (clr) begin
                    rem_nx   = '0;
                    state_nx = IDLE;
                end else if (add) begin
                    rem_nx = sat_add(remaining);
                end else if (go && !door) begin
                    start_nx = 1'b1;
                    pre_nx   = '0;
                    state_nx = ARM;
                end
            end

            ARM: begin
                if (heat)      state_nx = RUN;
                else if (door) state_nx = SET;
            end

            RUN: begin
                // Losing heat pauses immediately, even on the terminal count.
                if (!heat) begin
                    state_nx = HOLD;
                end else if (prescaler == PRE_LAST) begin
                    pre_nx = '0;
                    if (remaining != '0) begin
                        rem_nx = remaining - TW'(1);
                        if (remaining == TW'(1)) begin
                            finish_nx = 1'b1;
                            state_nx  = DONE;
                        end
                    end
                end else begin
                    pre_nx = prescaler + PW'(1);
                end
            end

            HOLD: begin
                // Prescaler is left untouched so partial seconds survive a pause.
                if (clr) begin
                    rem_nx   = '0;
                    pre_nx   = '0;
                    state_nx = IDLE;
                end else if (heat) begin
                    state_nx = RUN;
                end else if (add) begin
                    rem_nx = sat_add(remaining);
                end
            end

            DONE: begin
                if (door) state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
                rem_nx   = '0;
                pre_nx   = '0;
            end
        endcase

        running_nx = (state_nx == RUN);
    end

endmodule

// File: tb/tb_oven_timer.sv
module tb_oven_timer;

    localparam int TICK_DIV = 4;
    localparam int TW       = 8;
    localparam int STEP     = 10;

    logic          clk = 1'b0;
    logic          nrst;
    logic          add, clr, go, door, heat;
    logic          start, finish, running;
    logic [TW-1:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_total = 0;

    oven_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .add       (add),
        .clr       (clr),
        .go        (go),
        .door      (door),
        .heat      (heat),
        .start     (start),
        .finish    (finish),
        .remaining (remaining),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Every finish pulse over the whole run.
    always @(negedge clk) if (finish === 1'b1) fin_total <= fin_total + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_add();
        add = 1'b1; tick(); add = 1'b0;
    endtask

    task automatic p_go();
        go = 1'b1; tick(); go = 1'b0;
    endtask

    task automatic p_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        int fin_k;
        int fin_seen;

        nrst = 1'b0;
        add = 1'b0; clr = 1'b0; go = 1'b0; door = 1'b0; heat = 1'b0;
        #23;
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_start",     int'(start),     0);
        chk("rst_finish",    int'(finish),    0);
        chk("rst_running",   int'(running),   0);
        tick();
        nrst = 1'b1;
        tick();

        // go in IDLE with nothing programmed
        p_go();
        chk("idle_go_start", int'(start), 0);
        chk("idle_go_rem",   int'(remaining), 0);

        p_add();
        chk("add1_rem", int'(remaining), 10);

        // go with door open in SET
        door = 1'b1;
        p_go();
        chk("door_go_start", int'(start), 0);
        door = 1'b0;

        // go together with add: add wins, go dropped
        add = 1'b1; go = 1'b1; tick(); add = 1'b0; go = 1'b0;
        chk("addgo_rem",   int'(remaining), 20);
        chk("addgo_start", int'(start), 0);
        tick();
        chk("addgo_start2", int'(start), 0);

        // program and cook 20 s
        p_go();
        chk("go_start",   int'(start), 1);
        chk("go_running", int'(running), 0);
        tick();
        chk("arm_start_low", int'(start), 0);
        tick();
        heat = 1'b1;
        tick();
        chk("run_entered", int'(running), 1);
        chk("run_rem0",    int'(remaining), 20);
        fin_k = 0;
        fin_seen = 0;
        for (int k = 1; k <= 85; k++) begin
            tick();
            if (k == 3) chk("rem_before_tick", int'(remaining), 20);
            if (k == 4) chk("rem_first_tick",  int'(remaining), 19);
            if (k == 40) chk("rem_mid", int'(remaining), 10);
            if (finish) begin
                fin_seen++;
                if (fin_k == 0) fin_k = k;
            end
        end
        chk("finish_count", fin_seen, 1);
        chk("finish_cycle", fin_k, 80);
        chk("done_rem",     int'(remaining), 0);
        chk("done_running", int'(running), 0);
        heat = 1'b0;
        p_add();
        chk("done_add_ignored", int'(remaining), 0);
        door = 1'b1;
        tick();
        door = 1'b0;
        p_add();
        chk("idle_after_door", int'(remaining), 10);

        // pause / resume keeps partial seconds
        p_go();
        chk("go2_start", int'(start), 1);
        tick();
        heat = 1'b1;
        tick();
        tick();
        tick();                 // prescaler now 2
        heat = 1'b0;
        tick();
        chk("hold_running", int'(running), 0);
        for (int k = 0; k < 9; k++) tick();
        chk("hold_rem_frozen", int'(remaining), 10);
        heat = 1'b1;
        tick();
        chk("resume_running", int'(running), 1);
        tick();
        chk("resume_rem_1", int'(remaining), 10);
        tick();
        chk("resume_rem_2", int'(remaining), 9);

        // abort from HOLD, with an add while paused first
        heat = 1'b0;
        tick();
        p_add();
        chk("hold_add", int'(remaining), 19);
        p_clr();
        chk("abort_rem",     int'(remaining), 0);
        chk("abort_running", int'(running), 0);
        p_go();
        chk("abort_idle_go", int'(start), 0);

        // door opened in ARM returns to SET with time intact
        p_add();
        p_go();
        chk("go3_start", int'(start), 1);
        door = 1'b1;
        tick();
        door = 1'b0;
        chk("arm_door_rem", int'(remaining), 10);
        chk("arm_door_running", int'(running), 0);
        p_go();
        chk("reset_after_arm_go", int'(start), 1);

        // reset in the middle of cooking at 7 s
        heat = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) tick();
        chk("pre_reset_rem",     int'(remaining), 7);
        chk("pre_reset_running", int'(running), 1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_rem",     int'(remaining), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_finish",  int'(finish), 0);
        tick();
        tick();
        #2;
        nrst = 1'b1;
        tick();
        tick();
        chk("post_reset_running", int'(running), 0);
        chk("post_reset_rem",     int'(remaining), 0);
        heat = 1'b0;

        // saturation
        for (int k = 1; k <= 30; k++) begin
            p_add();
            if (k == 25) chk("sat_250", int'(remaining), 250);
            if (k == 26) chk("sat_255", int'(remaining), 255);
        end
        chk("sat_hold", int'(remaining), 255);
        p_clr();
        chk("set_clr", int'(remaining), 0);

        tick();
        chk("finish_total", fin_total, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
